uart_rx: RTL and testbench

- 8N1 UART receiver, 16x oversampled. Receive-side counterpart of the design's UART transmitter on the DE1-SoC serial link.
- Synchronises the asynchronous rx line, validates the start bit and samples each bit at mid-point.
- Presents each byte in a one-entry output register with a valid/ack handshake.
- Flags framing errors and overruns to the SDRAM/command logic.

---
 rtl/uart_rx.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled, with a one-entry valid/ack output register.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_err pulse output.
module uart_rx #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int unsigned TICK_DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned TICK_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SAMP_W     = $clog2(OVERSAMPLE);
    localparam int unsigned MID_SAMPLE = OVERSAMPLE / 2 - 1;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned BIT_W      = $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        PARITY    = 3'd5
`endif
    } state_t;

    state_t              state;
    logic                rx_m;
    logic                rx_s;
    logic [TICK_W-1:0]   tick_cnt;
    logic [SAMP_W-1:0]   samp_cnt;
    logic [BIT_W-1:0]    bit_idx;
    logic [DATA_W-1:0]   shift_reg;
    logic                tick_c;
    logic                mid_c;
`ifdef UART_RX_PARITY_EN
    logic                par_bad;
`endif

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign tick_c = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign mid_c  = tick_c && (samp_cnt == SAMP_W'(MID_SAMPLE));

    // Receive FSM with baud counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            samp_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            // A byte load later in this block takes priority over the ack
            if (data_ack) begin
                data_valid <= 1'b0;
            end

            if (state == IDLE) begin
                tick_cnt <= '0;
                samp_cnt <= '0;
            end else begin
                tick_cnt <= tick_c ? '0 : tick_cnt + TICK_W'(1);
                if (tick_c) begin
                    samp_cnt <= samp_cnt + SAMP_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state   <= START;
                        busy    <= 1'b1;
                        bit_idx <= '0;
                    end
                end

                START: begin
                    if (mid_c) begin
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end
                end

                DATA: begin
                    if (mid_c) begin
                        shift_reg <= {rx_s, shift_reg[DATA_W-1:1]};
                        if (bit_idx == BIT_W'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (mid_c) begin
                        par_bad    <= (rx_s != ^shift_reg);
                        parity_err <= (rx_s != ^shift_reg);
                        state      <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (mid_c) begin
                        if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                            if (!par_bad) begin
                                data       <= shift_reg;
                                data_valid <= 1'b1;
                                overrun    <= data_valid && !data_ack;
                            end
`else
                            data       <= shift_reg;
                            data_valid <= 1'b1;
                            overrun    <= data_valid && !data_ack;
`endif
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end
                    end
                end

                WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level reference model compared every cycle, plus directed literal checks.
module tb_uart_rx;

    localparam int BIT_CLK = 432;
    localparam int HALF    = 216;
    localparam int SYNC    = 3;
    localparam int HIST    = 131072;
`ifdef UART_RX_PARITY_EN
    localparam int STOP_J  = 10;
`else
    localparam int STOP_J  = 9;
`endif
    localparam int LATENCY = SYNC + HALF + STOP_J * BIT_CLK;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ack;
    logic       frame_err;
    logic       overrun;
    logic       busy;
    logic       perr_act;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    assign perr_act = parity_err;
`else
    assign perr_act = 1'b0;
`endif

    uart_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data       (data),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    int n_checks;
    int n_fail;
    int ack_mode;
    int ack_dly;
    logic par_bit;

    // line / ack / reset history, indexed by cycle
    logic line_h [HIST];
    logic ack_h  [HIST];
    logic rst_h  [HIST];

    // reference model state
    int         m_mode;   // 0 idle, 1 in frame, 2 waiting for line high
    int         m_start;
    logic [7:0] m_byte;
    logic       m_pbad;
    logic [7:0] e_data;
    logic       e_valid, e_ferr, e_ovr, e_busy, e_perr;

    // observation counters
    int rise_cyc, fall_cyc, ferr_cnt, ovr_cnt, perr_cnt;
    logic prev_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_start = 0;
        m_byte  = 8'h00;
        m_pbad  = 1'b0;
        e_data  = 8'h00;
        e_valid = 1'b0;
        e_ferr  = 1'b0;
        e_ovr   = 1'b0;
        e_busy  = 1'b0;
        e_perr  = 1'b0;
    endtask

    // Outputs after clock edge c, from the line as the receiver sees it (SYNC edges late)
    task automatic model_edge(input int c);
        logic seen, ack, was_valid;
        int off, j;
        e_ferr = 1'b0;
        e_ovr  = 1'b0;
        e_perr = 1'b0;
        if (c < SYNC) return;
        seen = line_h[c - SYNC];
        ack  = ack_h[c - 1];
        was_valid = e_valid;
        if (e_valid && ack) e_valid = 1'b0;
        if (m_mode == 0) begin
            if (!seen) begin
                m_mode  = 1;
                m_start = c;
            end
        end else if (m_mode == 1) begin
            off = c - m_start;
            if (off >= HALF && ((off - HALF) % BIT_CLK) == 0) begin
                j = (off - HALF) / BIT_CLK;
                if (j == 0) begin
                    if (seen) m_mode = 0;
                end else if (j <= 8) begin
                    m_byte[j-1] = seen;
                end else if (j < STOP_J) begin
                    m_pbad = (seen != ^m_byte);
                    e_perr = m_pbad;
                end else begin
                    if (seen) begin
                        if (!m_pbad) begin
                            e_data  = m_byte;
                            e_valid = 1'b1;
                            e_ovr   = was_valid && !ack;
                        end
                        m_mode = 0;
                    end else begin
                        e_ferr = 1'b1;
                        m_mode = 2;
                    end
                end
            end
        end else begin
            if (seen) m_mode = 0;
        end
        e_busy = (m_mode != 0);
    endtask

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Per-cycle model update and comparison, away from the active edge
    initial begin
        int c;
        logic [12:0] act_v, exp_v;
        model_reset();
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            c = cyc;
            if (c < HIST) begin
                line_h[c] = rst_n ? rx : 1'b1;
                ack_h[c]  = data_ack;
                rst_h[c]  = rst_n;
                if (!rst_n) begin
                    model_reset();
                end else if (c == 0 || !rst_h[c-1]) begin
                    e_ferr = 1'b0;
                    e_ovr  = 1'b0;
                    e_perr = 1'b0;
                end else begin
                    model_edge(c);
                end
                act_v = {perr_act, busy, overrun, frame_err, data_valid, data};
                exp_v = {e_perr, e_busy, e_ovr, e_ferr, e_valid, e_data};
                chk("outputs{perr,busy,ovr,ferr,valid,data}", 32'(act_v), 32'(exp_v));
            end
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (perr_act) perr_cnt++;
            if (data_valid && !prev_v) rise_cyc = c;
            if (!data_valid && prev_v) fall_cyc = c;
            prev_v = data_valid;
        end
    end

    // Consumer: acknowledges ack_dly cycles after it sees data_valid
    initial begin
        int vcnt;
        vcnt = 0;
        data_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (data_ack) begin
                data_ack = 1'b0;
                vcnt = 0;
            end else if (ack_mode != 0 && data_valid) begin
                vcnt++;
                if (vcnt > ack_dly) data_ack = 1'b1;
            end else begin
                vcnt = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_cyc, output int fall);
        rx = 1'b0;
        fall = cyc;
        step(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            step(BIT_CLK);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_bit;
        step(BIT_CLK);
`endif
        rx = stop;
        step(stop_cyc);
    endtask

    initial begin
        int fall, g, base_rise, base_ferr, base_ovr, kind, len;
        logic [7:0] b;
        n_checks = 0; n_fail = 0;
        rise_cyc = 0; fall_cyc = 0; ferr_cnt = 0; ovr_cnt = 0; perr_cnt = 0;
        rst_n = 1'b0; rx = 1'b1; ack_mode = 0; ack_dly = 5; par_bit = 1'b0;

        step(5);
        chk("reset_data", 32'(data), 32'h00);
        chk("reset_valid_busy_err", 32'({data_valid, busy, frame_err, overrun}), 32'h0);
        rst_n = 1'b1;
        step(20);

        // 0x55, ack 5 cycles after valid
        ack_mode = 1; ack_dly = 5; par_bit = 1'b0;
        send_frame(8'h55, 1'b1, BIT_CLK, fall);
        step(100);
        chk("t1_latency", 32'(rise_cyc - fall), 32'(LATENCY));
        chk("t1_data", 32'(data), 32'h55);
        chk("t1_ack_clear", 32'(fall_cyc - rise_cyc), 32'd6);
        chk("t1_no_err", 32'(ferr_cnt + ovr_cnt), 32'd0);

        // short low glitch
        base_rise = rise_cyc;
        rx = 1'b0; g = cyc;
        step(100);
        rx = 1'b1;
        step(118);
        chk("t2_busy_before_mid", 32'(busy), 32'd1);
        step(1);
        chk("t2_busy_after_mid", 32'(busy), 32'd0);
        step(200);
        chk("t2_no_valid", 32'(rise_cyc), 32'(base_rise));
        chk("t2_no_ferr", 32'(ferr_cnt), 32'd0);

        // 0xA3 with stop low and a long break
        par_bit = 1'b0;
        send_frame(8'hA3, 1'b0, 2000, fall);
        chk("t3_ferr_once", 32'(ferr_cnt), 32'd1);
        chk("t3_valid_low", 32'(data_valid), 32'd0);
        chk("t3_busy_in_break", 32'(busy), 32'd1);
        chk("t3_data_kept", 32'(data), 32'h55);
        rx = 1'b1;
        step(5);
        chk("t3_busy_released", 32'(busy), 32'd0);
        step(50);

        // back-to-back 0x01, 0x02 without ack
        ack_mode = 0; base_ovr = ovr_cnt; par_bit = 1'b1;
        send_frame(8'h01, 1'b1, BIT_CLK, fall);
        chk("t4_first_valid", 32'(data_valid), 32'd1);
        chk("t4_first_data", 32'(data), 32'h01);
        send_frame(8'h02, 1'b1, BIT_CLK, fall);
        step(50);
        chk("t4_overrun_once", 32'(ovr_cnt - base_ovr), 32'd1);
        chk("t4_data", 32'(data), 32'h02);
        chk("t4_valid", 32'(data_valid), 32'd1);
        ack_mode = 1; ack_dly = 0;
        step(10);
        chk("t4_acked", 32'(data_valid), 32'd0);

        // reset mid-way through bit 3 of 0xF0, then 0x3C
        base_ferr = ferr_cnt; base_ovr = ovr_cnt;
        rx = 1'b0; step(BIT_CLK);
        for (int i = 0; i < 3; i++) begin
            rx = 1'b0; step(BIT_CLK);
        end
        rx = 1'b0; step(HALF);
        rst_n = 1'b0;
        step(2);
        chk("t5_reset_data", 32'(data), 32'h00);
        chk("t5_reset_flags", 32'({data_valid, busy, frame_err, overrun}), 32'h0);
        rx = 1'b1;
        step(10);
        rst_n = 1'b1;
        step(20);
        ack_dly = 5; par_bit = 1'b0;
        send_frame(8'h3C, 1'b1, BIT_CLK, fall);
        step(100);
        chk("t5_data", 32'(data), 32'h3C);
        chk("t5_latency", 32'(rise_cyc - fall), 32'(LATENCY));
        chk("t5_no_err", 32'((ferr_cnt - base_ferr) + (ovr_cnt - base_ovr)), 32'd0);

`ifdef UART_RX_PARITY_EN
        par_bit = 1'b1;
        send_frame(8'h07, 1'b1, BIT_CLK, fall);
        step(100);
        chk("t6_data", 32'(data), 32'h07);
        chk("t6_valid_rose", 32'(rise_cyc - fall), 32'(LATENCY));
        chk("t6_no_perr", 32'(perr_cnt), 32'd0);
        base_rise = rise_cyc;
        par_bit = 1'b0;
        send_frame(8'h07, 1'b1, BIT_CLK, fall);
        step(100);
        chk("t6_perr_once", 32'(perr_cnt), 32'd1);
        chk("t6_no_reassert", 32'(rise_cyc), 32'(base_rise));
`endif

        // randomized traffic checked by the model alone
        for (int n = 0; n < 8; n++) begin
            b = 8'($urandom);
            kind = int'($urandom_range(0, 9));
            ack_mode = ($urandom_range(0, 3) != 0) ? 1 : 0;
            ack_dly = int'($urandom_range(0, 30));
            par_bit = (^b) ^ ($urandom_range(0, 4) == 0);
            if (kind == 0) begin
                len = int'($urandom_range(1, 150));
                rx = 1'b0; step(len);
                rx = 1'b1; step(300);
            end else if (kind == 1) begin
                send_frame(b, 1'b0, int'($urandom_range(432, 1500)), fall);
                rx = 1'b1; step(50);
            end else begin
                send_frame(b, 1'b1, int'($urandom_range(230, 600)), fall);
                step(int'($urandom_range(0, 200)));
            end
        end
        ack_mode = 1; ack_dly = 0;
        step(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
